tx_pulse_sequencer: RTL

Per-frame transmit pulse generator for the beamformer front end. Consumes the divided pulse-repetition clock from the secondary clock stage: each rising edge of that clock starts one transmit frame. During a frame, each of NUM_CH channels emits a square-wave burst after its own programmable delay, which steers and focuses the transmit beam. The block reports frame completion, frame count and dropped triggers to the control logic.

---
 rtl/tx_pkg.sv | 13 +
 rtl/tx_channel.sv | 92 +++++++++
 rtl/tx_pulse_sequencer.sv | 126 ++++++++++++
 3 files changed

// File: rtl/tx_pkg.sv
// Shared types and default sizing for the transmit pulse sequencer.
// TX_CH_MASK_EN (optional) is handled in tx_pulse_sequencer.sv.
package tx_pkg;
  localparam int DEF_NUM_CH  = 8;
  localparam int DEF_DELAY_W = 10;
  localparam int DEF_HALF_W  = 8;
  localparam int DEF_CYC_W   = 4;
  localparam int FRAME_CNT_W = 16;

  typedef enum logic {ST_IDLE, ST_FIRE} txState_t;

  typedef enum logic [1:0] {CH_IDLE, CH_DELAY, CH_PULSE} chPhase_t;
endpackage

// File: rtl/tx_channel.sv
// One transmit channel: delay countdown, then numCycles square-wave periods
// of halfPeriod high / halfPeriod low, then a sticky done flag until the next start.
module tx_channel
  import tx_pkg::*;
#(
  parameter int DELAY_W = DEF_DELAY_W,
  parameter int HALF_W  = DEF_HALF_W,
  parameter int CYC_W   = DEF_CYC_W
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               start,
  input  logic [DELAY_W-1:0] delay,
  input  logic [HALF_W-1:0]  halfPeriod,
  input  logic [CYC_W-1:0]   numCycles,
  output logic               tx,
  output logic               done
);

  chPhase_t           phase, phaseNext;
  logic [DELAY_W-1:0] delayCnt, delayNext;
  logic [HALF_W-1:0]  halfCnt, halfNext;
  logic [CYC_W-1:0]   cycCnt, cycNext;
  logic               txNext, doneNext;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      phase    <= CH_IDLE;
      delayCnt <= '0;
      halfCnt  <= '0;
      cycCnt   <= '0;
      tx       <= 1'b0;
      done     <= 1'b0;
    end else begin
      phase    <= phaseNext;
      delayCnt <= delayNext;
      halfCnt  <= halfNext;
      cycCnt   <= cycNext;
      tx       <= txNext;
      done     <= doneNext;
    end
  end

  always_comb begin
    phaseNext = phase;
    delayNext = delayCnt;
    halfNext  = halfCnt;
    cycNext   = cycCnt;
    txNext    = tx;
    doneNext  = done;
    if (start) begin
      phaseNext = CH_DELAY;
      delayNext = delay;
      txNext    = 1'b0;
      doneNext  = 1'b0;
    end else begin
      case (phase)
        CH_DELAY: begin
          if (delayCnt != '0) begin
            delayNext = delayCnt - 1'b1;
          end else if (halfPeriod == '0 || numCycles == '0) begin
            // Empty burst: finish at the same point a 2HC=0 burst would.
            doneNext  = 1'b1;
            phaseNext = CH_IDLE;
          end else begin
            txNext    = 1'b1;
            halfNext  = halfPeriod - 1'b1;
            cycNext   = numCycles - 1'b1;
            phaseNext = CH_PULSE;
          end
        end
        CH_PULSE: begin
          if (halfCnt != '0) begin
            halfNext = halfCnt - 1'b1;
          end else if (tx) begin
            txNext   = 1'b0;
            halfNext = halfPeriod - 1'b1;
          end else if (cycCnt == '0) begin
            doneNext  = 1'b1;
            phaseNext = CH_IDLE;
          end else begin
            cycNext  = cycCnt - 1'b1;
            txNext   = 1'b1;
            halfNext = halfPeriod - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/tx_pulse_sequencer.sv
// Per-frame transmit pulse sequencer: trigger edge detect, frame FSM, counters.
// Optional macro TX_CH_MASK_EN adds a per-channel ch_mask input captured at frame start.
module tx_pulse_sequencer
  import tx_pkg::*;
#(
  parameter int NUM_CH  = DEF_NUM_CH,
  parameter int DELAY_W = DEF_DELAY_W,
  parameter int HALF_W  = DEF_HALF_W,
  parameter int CYC_W   = DEF_CYC_W
) (
  input  logic                      clock,
  input  logic                      reset_n,
  input  logic                      dividedClk,
  input  logic                      enable,
  input  logic [NUM_CH*DELAY_W-1:0] delays,
  input  logic [HALF_W-1:0]         half_period,
  input  logic [CYC_W-1:0]          num_cycles,
`ifdef TX_CH_MASK_EN
  input  logic [NUM_CH-1:0]         ch_mask,
`endif
  output logic [NUM_CH-1:0]         tx_out,
  output logic                      busy,
  output logic                      frame_done,
  output logic                      overrun,
  output logic [FRAME_CNT_W-1:0]    frame_count
);

  logic              dclk_q, trig_r;
  txState_t          state, stateNext;
  logic              startFrame, finishFrame, dropTrig;
  logic [HALF_W-1:0] halfShadow;
  logic [CYC_W-1:0]  cycShadow;
  logic [NUM_CH-1:0] chTx, chDone;

  // Stage 0: trigger edge detect
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      dclk_q <= 1'b0;
      trig_r <= 1'b0;
    end else begin
      dclk_q <= dividedClk;
      trig_r <= dividedClk & ~dclk_q & enable;
    end
  end

  // Stage 1: frame FSM and status outputs
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= ST_IDLE;
      frame_done  <= 1'b0;
      overrun     <= 1'b0;
      frame_count <= '0;
      halfShadow  <= '0;
      cycShadow   <= '0;
    end else begin
      state      <= stateNext;
      frame_done <= finishFrame;
      overrun    <= dropTrig;
      if (finishFrame) frame_count <= frame_count + 1'b1;
      if (startFrame) begin
        halfShadow <= half_period;
        cycShadow  <= num_cycles;
      end
    end
  end

  always_comb begin
    stateNext   = state;
    startFrame  = 1'b0;
    finishFrame = 1'b0;
    dropTrig    = 1'b0;
    case (state)
      ST_IDLE: begin
        // A trigger landing in the frame_done cycle is still part of the old frame.
        if (trig_r && frame_done) begin
          dropTrig = 1'b1;
        end else if (trig_r) begin
          startFrame = 1'b1;
          stateNext  = ST_FIRE;
        end
      end
      ST_FIRE: begin
        dropTrig = trig_r;
        if (&chDone) begin
          finishFrame = 1'b1;
          stateNext   = ST_IDLE;
        end
      end
      default: stateNext = ST_IDLE;
    endcase
  end

  assign busy = (state == ST_FIRE);

  for (genvar i = 0; i < NUM_CH; i++) begin : gCh
    tx_channel #(
      .DELAY_W(DELAY_W),
      .HALF_W (HALF_W),
      .CYC_W  (CYC_W)
    ) uChannel (
      .clock     (clock),
      .reset_n   (reset_n),
      .start     (startFrame),
      .delay     (delays[i*DELAY_W +: DELAY_W]),
      .halfPeriod(halfShadow),
      .numCycles (cycShadow),
      .tx        (chTx[i]),
      .done      (chDone[i])
    );
  end

`ifdef TX_CH_MASK_EN
  logic [NUM_CH-1:0] maskShadow;

  // Masked channels still sequence their done flag so frame timing is unchanged.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) maskShadow <= '0;
    else if (startFrame) maskShadow <= ch_mask;
  end

  assign tx_out = chTx & maskShadow;
`else
  assign tx_out = chTx;
`endif

endmodule
